// File: rtl/lsu_pkg.sv
// Shared encodings for the data load/store unit: access sizes, RAM byte-enable
// codes, FSM states and the default RAM address region.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // The RAM uses its own byte-enable encoding, not a one-hot lane mask.
    localparam logic [3:0] BE_WORD    = 4'b0001;
    localparam logic [3:0] BE_HALF_HI = 4'b0010;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_B0      = 4'b1000;
    localparam logic [3:0] BE_B1      = 4'b1001;
    localparam logic [3:0] BE_B2      = 4'b1010;
    localparam logic [3:0] BE_B3      = 4'b1100;

    localparam logic [15:0] RAM_REGION_DEF = 16'h0010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_RESP
    } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store-side lane placement, byte-enable code and
// legality check; load-side lane extraction with sign/zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  i_st_size,
    input  logic [1:0]  i_st_off,
    input  logic [31:0] i_st_wdata,
    output logic [3:0]  o_st_be,
    output logic [31:0] o_st_wdata,
    output logic        o_st_bad,
    input  logic [1:0]  i_ld_size,
    input  logic [1:0]  i_ld_off,
    input  logic        i_ld_unsigned,
    input  logic [31:0] i_ld_rdata,
    output logic [31:0] o_ld_data
);

    logic [7:0]  w_ld_byte;
    logic [15:0] w_ld_half;

    always_comb begin
        o_st_be    = 4'b0000;
        o_st_wdata = 32'h0;
        o_st_bad   = 1'b0;
        case (i_st_size)
            SZ_WORD: begin
                if (i_st_off != 2'b00) begin
                    o_st_bad = 1'b1;
                end else begin
                    o_st_be    = BE_WORD;
                    o_st_wdata = i_st_wdata;
                end
            end
            SZ_HALF: begin
                if (i_st_off[0]) begin
                    o_st_bad = 1'b1;
                end else if (i_st_off[1]) begin
                    o_st_be    = BE_HALF_HI;
                    o_st_wdata = {i_st_wdata[15:0], 16'h0};
                end else begin
                    o_st_be    = BE_HALF_LO;
                    o_st_wdata = {16'h0, i_st_wdata[15:0]};
                end
            end
            SZ_BYTE: begin
                case (i_st_off)
                    2'd0: begin o_st_be = BE_B0; o_st_wdata = {24'h0, i_st_wdata[7:0]}; end
                    2'd1: begin o_st_be = BE_B1; o_st_wdata = {16'h0, i_st_wdata[7:0], 8'h0}; end
                    2'd2: begin o_st_be = BE_B2; o_st_wdata = {8'h0, i_st_wdata[7:0], 16'h0}; end
                    default: begin o_st_be = BE_B3; o_st_wdata = {i_st_wdata[7:0], 24'h0}; end
                endcase
            end
            default: o_st_bad = 1'b1;
        endcase
    end

    always_comb begin
        case (i_ld_off)
            2'd0:    w_ld_byte = i_ld_rdata[7:0];
            2'd1:    w_ld_byte = i_ld_rdata[15:8];
            2'd2:    w_ld_byte = i_ld_rdata[23:16];
            default: w_ld_byte = i_ld_rdata[31:24];
        endcase
        w_ld_half = i_ld_off[1] ? i_ld_rdata[31:16] : i_ld_rdata[15:0];
        case (i_ld_size)
            SZ_BYTE: o_ld_data = {{24{~i_ld_unsigned & w_ld_byte[7]}}, w_ld_byte};
            SZ_HALF: o_ld_data = {{16{~i_ld_unsigned & w_ld_half[15]}}, w_ld_half};
            default: o_ld_data = i_ld_rdata;
        endcase
    end

endmodule

// File: rtl/data_lsu.sv
// Load/store initiator: accepts one core access, drives the data RAM
// req/gnt/rvalid handshake and returns extended load data or an error.
module data_lsu
    import lsu_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 16,
    parameter logic [15:0] RAM_REGION     = RAM_REGION_DEF
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        lsu_valid_in,
    output logic        lsu_ready_o,
    input  logic        lsu_we_in,
    input  logic [1:0]  lsu_size_in,
    input  logic        lsu_unsigned_in,
    input  logic [31:0] lsu_addr_in,
    input  logic [31:0] lsu_wdata_in,
    output logic        lsu_done_o,
    output logic [31:0] lsu_rdata_o,
    output logic        lsu_err_o,
    output logic        data_req_o,
    output logic [31:0] data_add_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_gnt_in,
    input  logic        data_rvalid_in,
    input  logic [31:0] data_rdata_in
);

    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_e       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ready;
    logic             r_done;
    logic             r_err;
    logic [31:0]      r_rdata;
    logic             r_req;
    logic [31:0]      r_addr;
    logic             r_we;
    logic [3:0]       r_be;
    logic [31:0]      r_wdata;
    logic [1:0]       r_size;
    logic             r_unsigned;

    logic [3:0]       w_st_be;
    logic [31:0]      w_st_wdata;
    logic             w_st_bad;
    logic [31:0]      w_ld_data;
    logic             w_timeout;
    logic             w_rvalid;

    lsu_align u_align (
        .i_st_size     (lsu_size_in),
        .i_st_off      (lsu_addr_in[1:0]),
        .i_st_wdata    (lsu_wdata_in),
        .o_st_be       (w_st_be),
        .o_st_wdata    (w_st_wdata),
        .o_st_bad      (w_st_bad),
        .i_ld_size     (r_size),
        .i_ld_off      (r_addr[1:0]),
        .i_ld_unsigned (r_unsigned),
        .i_ld_rdata    (data_rdata_in),
        .o_ld_data     (w_ld_data)
    );

    assign w_timeout = (r_cnt == CNT_LAST);
    // Outside the RAM region rvalid is never legitimate, so such loads finish by timeout.
    assign w_rvalid  = data_rvalid_in && (r_addr[31:16] == RAM_REGION);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_ready    <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_rdata    <= 32'h0;
            r_req      <= 1'b0;
            r_addr     <= 32'h0;
            r_we       <= 1'b0;
            r_be       <= 4'b0000;
            r_wdata    <= 32'h0;
            r_size     <= 2'b00;
            r_unsigned <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (lsu_valid_in && r_ready) begin
                        r_ready <= 1'b0;
                        if (w_st_bad) begin
                            r_state <= ST_RESP;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                            r_rdata <= 32'h0;
                        end else begin
                            r_state    <= ST_REQ;
                            r_req      <= 1'b1;
                            r_cnt      <= '0;
                            r_addr     <= lsu_addr_in;
                            r_we       <= lsu_we_in;
                            r_be       <= w_st_be;
                            r_wdata    <= w_st_wdata;
                            r_size     <= lsu_size_in;
                            r_unsigned <= lsu_unsigned_in;
                        end
                    end
                end
                ST_REQ: begin
                    if (data_gnt_in) begin
                        r_req <= 1'b0;
                        if (r_we || w_rvalid) begin
                            r_state <= ST_RESP;
                            r_done  <= 1'b1;
                            r_err   <= 1'b0;
                            r_rdata <= r_we ? 32'h0 : w_ld_data;
                        end else begin
                            r_state <= ST_WAIT;
                            r_cnt   <= '0;
                        end
                    end else if (w_timeout) begin
                        r_req   <= 1'b0;
                        r_state <= ST_RESP;
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                        r_rdata <= 32'h0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (w_rvalid) begin
                        r_state <= ST_RESP;
                        r_done  <= 1'b1;
                        r_err   <= 1'b0;
                        r_rdata <= w_ld_data;
                    end else if (w_timeout) begin
                        r_state <= ST_RESP;
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                        r_rdata <= 32'h0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_err   <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign lsu_ready_o  = r_ready;
    assign lsu_done_o   = r_done;
    assign lsu_err_o    = r_err;
    assign lsu_rdata_o  = r_rdata;
    assign data_req_o   = r_req;
    assign data_add_o   = {r_addr[31:16], 2'b00, r_addr[15:2]};
    assign data_we_o    = r_we;
    assign data_be_o    = r_be;
    assign data_wdata_o = r_wdata;

endmodule

// File: tb/tb_data_lsu.sv
// Directed bench for data_lsu with a combinational RAM responder.
module tb_data_lsu;

    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b0;
    logic        lsu_valid_in = 1'b0;
    logic        lsu_ready_o;
    logic        lsu_we_in = 1'b0;
    logic [1:0]  lsu_size_in = 2'b00;
    logic        lsu_unsigned_in = 1'b0;
    logic [31:0] lsu_addr_in = 32'h0;
    logic [31:0] lsu_wdata_in = 32'h0;
    logic        lsu_done_o;
    logic [31:0] lsu_rdata_o;
    logic        lsu_err_o;
    logic        data_req_o;
    logic [31:0] data_add_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_wdata_o;
    logic        data_gnt_in;
    logic        data_rvalid_in;
    logic [31:0] data_rdata_in;

    logic        gnt_en = 1'b1;
    logic        rv_en = 1'b1;
    logic [31:0] ram_word = 32'h0;
    logic        req_q = 1'b0;
    int          req_edges = 0;
    int          n_pass = 0;
    int          n_total = 0;

    // Captured per transaction by do_req
    int          t_lat;
    logic [31:0] t_add, t_wdata;
    logic [3:0]  t_be;
    logic        t_we;

    always #5 clk_in = ~clk_in;

    assign data_gnt_in    = data_req_o & gnt_en;
    assign data_rvalid_in = data_req_o & gnt_en & rv_en;
    assign data_rdata_in  = ram_word;

    always @(posedge clk_in) begin
        if (data_req_o && !req_q) req_edges <= req_edges + 1;
        req_q <= data_req_o;
    end

    data_lsu dut (
        .clk_in          (clk_in),
        .rst_n_in        (rst_n_in),
        .lsu_valid_in    (lsu_valid_in),
        .lsu_ready_o     (lsu_ready_o),
        .lsu_we_in       (lsu_we_in),
        .lsu_size_in     (lsu_size_in),
        .lsu_unsigned_in (lsu_unsigned_in),
        .lsu_addr_in     (lsu_addr_in),
        .lsu_wdata_in    (lsu_wdata_in),
        .lsu_done_o      (lsu_done_o),
        .lsu_rdata_o     (lsu_rdata_o),
        .lsu_err_o       (lsu_err_o),
        .data_req_o      (data_req_o),
        .data_add_o      (data_add_o),
        .data_we_o       (data_we_o),
        .data_be_o       (data_be_o),
        .data_wdata_o    (data_wdata_o),
        .data_gnt_in     (data_gnt_in),
        .data_rvalid_in  (data_rvalid_in),
        .data_rdata_in   (data_rdata_in)
    );

    // Issue one access at a sample point (#1 after an edge); accept cycle = 0,
    // t_lat = cycle in which done is seen.
    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata);
        int w;
        w = 0;
        while (!lsu_ready_o && w < 10) begin
            @(posedge clk_in); #1; w++;
        end
        t_add = 32'h0; t_be = 4'h0; t_wdata = 32'h0; t_we = 1'b0;
        lsu_valid_in = 1'b1; lsu_we_in = we; lsu_size_in = size;
        lsu_unsigned_in = uns; lsu_addr_in = addr; lsu_wdata_in = wdata;
        @(posedge clk_in); #1;
        lsu_valid_in = 1'b0;
        t_lat = 1;
        while (!lsu_done_o && t_lat < 40) begin
            if (data_req_o) begin
                t_add = data_add_o; t_be = data_be_o; t_wdata = data_wdata_o; t_we = data_we_o;
            end
            @(posedge clk_in); #1;
            t_lat++;
        end
    endtask

    task automatic test_reset();
        rst_n_in = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        n_total++; if (lsu_ready_o !== 1'b1) $display("FAIL reset_ready got %b want 1", lsu_ready_o); else n_pass++;
        n_total++; if (data_req_o !== 1'b0) $display("FAIL reset_req got %b want 0", data_req_o); else n_pass++;
        n_total++; if (lsu_done_o !== 1'b0 || lsu_err_o !== 1'b0) $display("FAIL reset_done_err got %b%b want 00", lsu_done_o, lsu_err_o); else n_pass++;
        n_total++; if (lsu_rdata_o !== 32'h0 || data_add_o !== 32'h0) $display("FAIL reset_data got %h/%h want 0/0", lsu_rdata_o, data_add_o); else n_pass++;
        rst_n_in = 1'b1;
        @(posedge clk_in); #1;
    endtask

    task automatic test_word();
        gnt_en = 1'b1; rv_en = 1'b1;
        do_req(1'b1, 2'b10, 1'b0, 32'h0010_0008, 32'hDEAD_BEEF);
        n_total++; if (t_add !== 32'h0010_0002) $display("FAIL sw_add got %h want 00100002", t_add); else n_pass++;
        n_total++; if (t_be !== 4'b0001 || t_we !== 1'b1) $display("FAIL sw_be_we got %b/%b want 0001/1", t_be, t_we); else n_pass++;
        n_total++; if (t_wdata !== 32'hDEAD_BEEF) $display("FAIL sw_wdata got %h want deadbeef", t_wdata); else n_pass++;
        n_total++; if (t_lat !== 2 || lsu_err_o !== 1'b0) $display("FAIL sw_lat_err got %0d/%b want 2/0", t_lat, lsu_err_o); else n_pass++;
        ram_word = 32'hDEAD_BEEF;
        do_req(1'b0, 2'b10, 1'b0, 32'h0010_0008, 32'h0);
        n_total++; if (lsu_rdata_o !== 32'hDEAD_BEEF) $display("FAIL lw_rdata got %h want deadbeef", lsu_rdata_o); else n_pass++;
        n_total++; if (t_lat !== 2 || lsu_err_o !== 1'b0 || t_we !== 1'b0) $display("FAIL lw_lat_err_we got %0d/%b/%b want 2/0/0", t_lat, lsu_err_o, t_we); else n_pass++;
    endtask

    task automatic test_byte();
        do_req(1'b1, 2'b00, 1'b0, 32'h0010_0013, 32'h0000_005A);
        n_total++; if (t_be !== 4'b1100 || t_wdata !== 32'h5A00_0000) $display("FAIL sb3 got %b/%h want 1100/5a000000", t_be, t_wdata); else n_pass++;
        do_req(1'b1, 2'b00, 1'b0, 32'h0010_0011, 32'hFFFF_FF3C);
        n_total++; if (t_be !== 4'b1001 || t_wdata !== 32'h0000_3C00) $display("FAIL sb1 got %b/%h want 1001/00003c00", t_be, t_wdata); else n_pass++;
        ram_word = 32'h8000_0000;
        do_req(1'b0, 2'b00, 1'b0, 32'h0010_0013, 32'h0);
        n_total++; if (lsu_rdata_o !== 32'hFFFF_FF80) $display("FAIL lb_signed got %h want ffffff80", lsu_rdata_o); else n_pass++;
        do_req(1'b0, 2'b00, 1'b1, 32'h0010_0013, 32'h0);
        n_total++; if (lsu_rdata_o !== 32'h0000_0080) $display("FAIL lbu got %h want 00000080", lsu_rdata_o); else n_pass++;
    endtask

    task automatic test_half();
        ram_word = 32'h8001_1234;
        do_req(1'b0, 2'b01, 1'b0, 32'h0010_0002, 32'h0);
        n_total++; if (lsu_rdata_o !== 32'hFFFF_8001 || t_be !== 4'b0010) $display("FAIL lh_hi got %h/%b want ffff8001/0010", lsu_rdata_o, t_be); else n_pass++;
        do_req(1'b0, 2'b01, 1'b1, 32'h0010_0000, 32'h0);
        n_total++; if (lsu_rdata_o !== 32'h0000_1234 || t_be !== 4'b0011) $display("FAIL lhu_lo got %h/%b want 00001234/0011", lsu_rdata_o, t_be); else n_pass++;
        do_req(1'b1, 2'b01, 1'b0, 32'h0010_0002, 32'hABCD_9876);
        n_total++; if (t_wdata !== 32'h9876_0000) $display("FAIL sh_hi_wdata got %h want 98760000", t_wdata); else n_pass++;
    endtask

    task automatic test_misalign();
        int e0;
        e0 = req_edges;
        do_req(1'b0, 2'b10, 1'b0, 32'h0010_0006, 32'h0);
        n_total++; if (t_lat !== 1 || lsu_err_o !== 1'b1) $display("FAIL mis_word got %0d/%b want 1/1", t_lat, lsu_err_o); else n_pass++;
        do_req(1'b0, 2'b11, 1'b0, 32'h0010_0000, 32'h0);
        n_total++; if (t_lat !== 1 || lsu_err_o !== 1'b1) $display("FAIL size11 got %0d/%b want 1/1", t_lat, lsu_err_o); else n_pass++;
        do_req(1'b1, 2'b01, 1'b0, 32'h0010_0001, 32'h0);
        n_total++; if (t_lat !== 1 || lsu_err_o !== 1'b1) $display("FAIL mis_half got %0d/%b want 1/1", t_lat, lsu_err_o); else n_pass++;
        @(posedge clk_in); #1;
        n_total++; if (req_edges !== e0) $display("FAIL mis_no_req got %0d edges want %0d", req_edges, e0); else n_pass++;
    endtask

    task automatic test_timeout();
        gnt_en = 1'b1; rv_en = 1'b0;
        ram_word = 32'h1234_5678;
        do_req(1'b0, 2'b10, 1'b0, 32'h0020_0000, 32'h0);
        n_total++; if (t_lat !== 18 || lsu_err_o !== 1'b1) $display("FAIL to_wait got %0d/%b want 18/1", t_lat, lsu_err_o); else n_pass++;
        n_total++; if (lsu_rdata_o !== 32'h0) $display("FAIL to_rdata got %h want 0", lsu_rdata_o); else n_pass++;
        gnt_en = 1'b0;
        do_req(1'b1, 2'b10, 1'b0, 32'h0010_0000, 32'h1);
        n_total++; if (t_lat !== 17 || lsu_err_o !== 1'b1) $display("FAIL to_req got %0d/%b want 17/1", t_lat, lsu_err_o); else n_pass++;
        gnt_en = 1'b1; rv_en = 1'b1;
    endtask

    task automatic test_back_to_back();
        int dones, gap, min_gap, seen_high;
        dones = 0; gap = 0; min_gap = 99; seen_high = 0;
        @(posedge clk_in); #1;
        lsu_valid_in = 1'b1; lsu_we_in = 1'b1; lsu_size_in = 2'b10;
        lsu_addr_in = 32'h0010_0004; lsu_wdata_in = 32'h1111_2222;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk_in); #1;
            if (lsu_done_o) dones++;
            if (data_req_o) begin
                if (seen_high != 0 && gap > 0 && gap < min_gap) min_gap = gap;
                seen_high = 1; gap = 0;
            end else if (seen_high != 0) begin
                gap++;
            end
        end
        lsu_valid_in = 1'b0;
        n_total++; if (dones < 3) $display("FAIL b2b_dones got %0d want >=3", dones); else n_pass++;
        n_total++; if (min_gap !== 2) $display("FAIL b2b_gap got %0d want 2", min_gap); else n_pass++;
        repeat (3) @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset_in_wait();
        int saw_done;
        saw_done = 0;
        gnt_en = 1'b1; rv_en = 1'b0;
        lsu_valid_in = 1'b1; lsu_we_in = 1'b0; lsu_size_in = 2'b10;
        lsu_addr_in = 32'h0010_0000;
        @(posedge clk_in); #1;
        lsu_valid_in = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        rst_n_in = 1'b0;
        #1;
        n_total++; if (data_req_o !== 1'b0 || lsu_ready_o !== 1'b1) $display("FAIL rst_wait got req=%b rdy=%b want 0/1", data_req_o, lsu_ready_o); else n_pass++;
        @(posedge clk_in); #1;
        rst_n_in = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk_in); #1;
            if (lsu_done_o) saw_done++;
        end
        n_total++; if (saw_done !== 0 || data_req_o !== 1'b0) $display("FAIL rst_wait_quiet got done=%0d req=%b want 0/0", saw_done, data_req_o); else n_pass++;
        rv_en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_misalign();
        test_timeout();
        test_back_to_back();
        test_reset_in_wait();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/data_lsu.md
Name: data_lsu

Overview:
- Load/store initiator that drives the data RAM request port on behalf of the core.
- Accepts one load or store per transaction from the core.
- Translates the core byte address into the RAM's word index and RAM-specific byte-enable code, and places store data into the correct lane.
- Runs the req/gnt/rvalid handshake, then returns aligned, sign/zero-extended load data or an error to the core.

Parameters:
- TIMEOUT_CYCLES, 16, cycles to wait for gnt or rvalid before flagging an error; counter width is clog2(TIMEOUT_CYCLES+1).
- RAM_REGION, 16'h0010, expected value of address bits [31:16] for the data RAM.

Ports:
- clk_in  input  1  clock; all state changes on rising edge.
- rst_n_in  input  1  asynchronous active-low reset.
- lsu_valid_in  input  1  core request valid.
- lsu_ready_o  output  1  high in IDLE; the request is accepted when valid and ready are both high.
- lsu_we_in  input  1  1=store, 0=load.
- lsu_size_in  input  2  00=byte, 01=half, 10=word; 11 is illegal.
- lsu_unsigned_in  input  1  zero-extend the load when 1.
- lsu_addr_in  input  32  byte address.
- lsu_wdata_in  input  32  store data, right-aligned.
- lsu_done_o  output  1  one-cycle completion pulse.
- lsu_rdata_o  output  32  extended load data; valid with done and held until the next done.
- lsu_err_o  output  1  valid with done: misaligned access, illegal size, or timeout.
- data_req_o  output  1  RAM request (the RAM is edge-sensitive on it).
- data_add_o  output  32  {addr[31:16], 2'b00, addr[15:2]}.
- data_we_o  output  1  RAM write enable.
- data_be_o  output  4  RAM byte-enable code.
- data_wdata_o  output  32  lane-placed store data.
- data_gnt_in  input  1  RAM grant.
- data_rvalid_in  input  1  RAM read valid.
- data_rdata_in  input  32  RAM read data.

Behaviour:
- Reset values: all outputs 0 except lsu_ready_o=1; state IDLE; counter 0. Reset asserted mid-transaction drops data_req_o at once with no done pulse.
- Byte-enable code and lanes, by size and addr[1:0]:
  - Word, offset 0: be 0001, full 32 bits.
  - Half, offset 0: be 0011, lane [15:0].
  - Half, offset 2: be 0010, lane [31:16].
  - Byte, offset 0: be 1000, lane [7:0].
  - Byte, offset 1: be 1001, lane [15:8].
  - Byte, offset 2: be 1010, lane [23:16].
  - Byte, offset 3: be 1100, lane [31:24].
- Unused store lanes are driven 0.
- Misaligned accesses (word with addr[1:0]≠0, half with addr[0]=1) and size 11: no RAM request; done and err pulse the next cycle.
- FSM states: IDLE, REQ, WAIT, RESP.
  - IDLE: on valid&ready with a legal access, register addr, be, wdata, we, size and unsigned; go to REQ with data_req_o=1 from the next cycle.
  - REQ: hold data_req_o and all data_* outputs stable. On gnt: a store goes to RESP; a load goes to RESP if rvalid is high in the same cycle, otherwise to WAIT.
  - WAIT: data_req_o=0; address and we stay held, because the RAM's read data depends combinationally on we. On rvalid, capture and extend the read data, then go to RESP.
  - RESP: done=1 for one cycle; data_req_o=0; return to IDLE. This guarantees at least two low cycles on req between transactions.
- Timeout: the counter resets on entry to REQ and to WAIT. If it reaches TIMEOUT_CYCLES in either state, go to RESP with err=1 and lsu_rdata_o=0. This covers addresses outside RAM_REGION, where the RAM grants but never asserts rvalid.
- Loads extract the same lane as the store mapping, then sign- or zero-extend to 32 bits.
- An address outside RAM_REGION is still issued; it completes through the timeout path.
- Latency for an in-region load or store with a same-cycle gnt: accept at cycle 0, req at cycle 1, done at cycle 2.
- A new request arriving while busy is not accepted (ready=0).

Decomposition:
- Package lsu_pkg holds:
  - size encodings: SZ_BYTE, SZ_HALF, SZ_WORD;
  - RAM byte-enable constants: BE_WORD=0001, BE_HALF_HI=0010, BE_HALF_LO=0011, BE_B0=1000, BE_B1=1001, BE_B2=1010, BE_B3=1100;
  - the state enum;
  - default RAM_REGION.
- Sub-module lsu_align (combinational):
  - store side: lane placement, be code, misalign flag;
  - load side: lane extraction and extension.
- The FSM, timeout counter and registers live in data_lsu.

Test Plan:
- Store word 0xDEADBEEF at 0x0010_0008: data_add_o=0x0010_0002, be=0001, wdata=0xDEADBEEF. Load word at the same address: lsu_rdata_o=0xDEADBEEF, err=0, done at cycle 2.
- Store byte 0x5A at 0x0010_0013: be=1100, wdata=0x5A00_0000. Load byte signed there with RAM word 0x8000_0000: rdata=0xFFFF_FF80; unsigned load: 0x0000_0080.
- Load half signed at offset 2 with RAM word 0x8001_1234: rdata=0xFFFF_8001. Offset 0, unsigned: 0x0000_1234.
- Load word at 0x0010_0006: no data_req_o edge, err=1 and done on the next cycle. Size 11: same response.
- Load from 0x0020_0000 with gnt but no rvalid: done with err=1 after TIMEOUT_CYCLES in WAIT, rdata=0.
- Back-to-back requests with valid held high: req low for ≥2 cycles between transactions. Reset pulse while in WAIT: req=0, ready=1, no done.
